// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - UART receiver control-word bit indices, FSM state encoding, vote helper
package uart_receiver_pkg;

  localparam int CTRL_8BIT  = 3;
  localparam int CTRL_PAR   = 2;
  localparam int CTRL_2STOP = 1;
  localparam int CTRL_ODD   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_sync.sv
// rtl/uart_receiver_sync.sv - Rx line synchroniser with fall strobe; UART_RX_MAJORITY_EN adds a 3-sample vote
module uart_receiver_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_bit,
  output logic o_fall
);

`ifdef UART_RX_MAJORITY_EN
  localparam int DEPTH = SYNC_STAGES + 2;
`else
  localparam int DEPTH = SYNC_STAGES + 1;
`endif

  // Index SYNC_STAGES is the nominal sample; one stage on each side gives the vote window.
  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '1;
    else          r_sync <= {r_sync[DEPTH-2:0], i_line};
  end

  assign o_fall = r_sync[SYNC_STAGES] & ~r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  assign o_bit = uart_receiver_pkg::maj3(r_sync[SYNC_STAGES-1], r_sync[SYNC_STAGES],
                                         r_sync[SYNC_STAGES+1]);
`else
  assign o_bit = r_sync[SYNC_STAGES];
`endif

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receiver: frame FSM, bit timing, shift register, output/status registers
// Optional build macro UART_RX_MAJORITY_EN selects majority-voted bit sampling.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic       Rx_line,
  input  logic [3:0] control,
  input  logic       Rx_ack,
  output logic [7:0] Rx_data,
  output logic       Rx_fg,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic          w_bit;
  logic          w_fall;
  rx_state_t     r_state;
  rx_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [3:0]    r_ctrl;
  logic          r_perr;
  logic          r_ferr;
  logic [7:0]    r_rx_data;
  logic          r_fg;
  logic          r_perr_out;
  logic          r_ferr_out;
  logic          r_ovr;
  logic          w_half;
  logic          w_full;
  logic          w_last_data;
  logic          w_final_stop;
  logic [7:0]    w_data_out;
  logic          w_par_exp;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  uart_receiver_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (baud_clk),
    .i_rst_n (w_rst_n),
    .i_line  (Rx_line),
    .o_bit   (w_bit),
    .o_fall  (w_fall)
  );

  assign w_half      = (r_cnt == HALF_M1);
  assign w_full      = (r_cnt == FULL_M1);
  assign w_last_data = (r_bit_cnt == (r_ctrl[CTRL_8BIT] ? 3'd7 : 3'd6));
  assign w_data_out  = r_ctrl[CTRL_8BIT] ? r_shift : {1'b0, r_shift[7:1]};
  assign w_par_exp   = r_ctrl[CTRL_ODD] ? ~^w_data_out : ^w_data_out;

  always_ff @(posedge baud_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_final_stop = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_fall) w_state_nxt = ST_START;
      ST_START:  if (w_half) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_full && w_last_data)
                   w_state_nxt = r_ctrl[CTRL_PAR] ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (w_full) w_state_nxt = ST_STOP1;
      ST_STOP1: begin
        if (w_full) begin
          if (r_ctrl[CTRL_2STOP]) begin
            w_state_nxt = ST_STOP2;
          end else begin
            w_final_stop = 1'b1;
            w_state_nxt  = w_bit ? ST_IDLE : ST_BREAK;
          end
        end
      end
      ST_STOP2: begin
        if (w_full) begin
          w_final_stop = 1'b1;
          w_state_nxt  = w_bit ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK:  if (w_bit) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_ctrl    <= 4'h0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || r_state == ST_BREAK || (r_state == ST_START && w_half) || w_full)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);

      if (r_state == ST_IDLE) r_ctrl <= control;

      if (r_state == ST_START) begin
        r_bit_cnt <= 3'd0;
        r_perr    <= 1'b0;
        r_ferr    <= 1'b0;
      end

      if (r_state == ST_DATA && w_full) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (r_state == ST_PARITY && w_full) r_perr <= (w_bit != w_par_exp);

      if ((r_state == ST_STOP1 || r_state == ST_STOP2) && w_full && !w_bit) r_ferr <= 1'b1;
    end
  end

  // A frame completing in the same cycle as an acknowledge replaces the held one.
  always_ff @(posedge baud_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_data  <= 8'h00;
      r_fg       <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_ovr      <= 1'b0;
    end else if (w_final_stop && (!r_fg || Rx_ack)) begin
      r_rx_data  <= w_data_out;
      r_perr_out <= r_perr;
      r_ferr_out <= r_ferr | ~w_bit;
      r_fg       <= 1'b1;
      if (r_fg) r_ovr <= 1'b0;
    end else if (w_final_stop) begin
      r_ovr <= 1'b1;
    end else if (Rx_ack && r_fg) begin
      r_fg       <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_ovr      <= 1'b0;
    end
  end

  assign Rx_data    = r_rx_data;
  assign Rx_fg      = r_fg;
  assign parity_err = r_perr_out;
  assign frame_err  = r_ferr_out;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver: directed frames, errors, overrun, glitch, reset
module tb_uart_receiver;

  localparam int OS   = 16;
  localparam int SYNC = 2;

  logic       baud_clk = 1'b0;
  logic       rst_n;
  logic       Rx_line;
  logic [3:0] control;
  logic       Rx_ack;
  logic [7:0] Rx_data;
  logic       Rx_fg;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
    .baud_clk   (baud_clk),
    .rst_n      (rst_n),
    .Rx_line    (Rx_line),
    .control    (control),
    .Rx_ack     (Rx_ack),
    .Rx_data    (Rx_data),
    .Rx_fg      (Rx_fg),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 baud_clk = ~baud_clk;
  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe,
                              input int nbits, input int par, input int nstop);
    exp_t e;
    e.d   = d;
    e.pe  = pe;
    e.fe  = fe;
    e.lat = (1 + nbits + par + nstop) * OS - OS / 2 + SYNC + 1;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input logic par_v, input int nstop, input logic stop_v,
                            input bit glitch);
    logic [11:0] b;
    int          n;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < nbits; i++) b[1 + i] = d[i];
    n = 1 + nbits;
    if (par_en) begin
      b[n] = par_v;
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      b[n] = stop_v;
      n++;
    end
    start_cyc = cyc;
    for (int k = 0; k < n; k++) begin
      for (int j = 1; j <= OS; j++) begin
        Rx_line = (glitch && j == OS / 2) ? ~b[k] : b[k];
        tick();
      end
    end
    Rx_line = 1'b1;
  endtask

  task automatic wait_fg(input string name);
    int k;
    k = 0;
    while (!Rx_fg && k < 300) begin
      @(negedge baud_clk);
      k++;
    end
    chk({name, "_fg"}, {31'd0, Rx_fg}, 32'd1);
  endtask

  task automatic ack();
    Rx_ack = 1'b1;
    tick();
    Rx_ack = 1'b0;
    @(negedge baud_clk);
    chk("ack_clears_fg", {31'd0, Rx_fg}, 32'd0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, {24'd0, Rx_data}, 32'd0);
    chk({tag, "_fg"}, {31'd0, Rx_fg}, 32'd0);
    chk({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask

  // Monitor: every rising Rx_fg is one delivered frame, checked against the oldest expectation.
  initial begin
    logic fg_prev;
    exp_t e;
    fg_prev = 1'b0;
    forever begin
      @(negedge baud_clk);
      if (Rx_fg && !fg_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", {24'd0, Rx_data}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("rx_data", {24'd0, Rx_data}, {24'd0, e.d});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
          chk("latency", cyc - start_cyc, e.lat);
        end
      end
      fg_prev = Rx_fg;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    Rx_line = 1'b1;
    control = 4'b1000;
    Rx_ack  = 1'b0;
    repeat (3) @(posedge baud_clk);
    @(negedge baud_clk);
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // 8N1 0xA5
    control = 4'b1000;
    expect_frame(8'hA5, 1'b0, 1'b0, 8, 0, 1);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_fg("a5");
    ack();

    // 7 bits, odd parity, 2 stops: 0x55 has four ones, so odd parity bit is 1
    control = 4'b0111;
    repeat (4) tick();
    expect_frame(8'h55, 1'b0, 1'b0, 7, 1, 2);
    send_frame(8'h55, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    wait_fg("par_ok");
    ack();
    expect_frame(8'h55, 1'b1, 1'b0, 7, 1, 2);
    send_frame(8'h55, 7, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    wait_fg("par_bad");
    ack();
    chk("perr_cleared", {31'd0, parity_err}, 32'd0);

    // Stop bit driven low
    control = 4'b1000;
    repeat (4) tick();
    expect_frame(8'h3C, 1'b0, 1'b1, 8, 0, 1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    repeat (8) tick();
    wait_fg("stop_low");
    ack();

    // Break: line low for three frame times yields exactly one all-zero framing-error frame
    expect_frame(8'h00, 1'b0, 1'b1, 8, 0, 1);
    start_cyc = cyc;
    Rx_line = 1'b0;
    repeat (3 * 10 * OS) tick();
    Rx_line = 1'b1;
    repeat (40) tick();
    @(negedge baud_clk);
    chk("break_fg", {31'd0, Rx_fg}, 32'd1);
    chk("break_no_ovr", {31'd0, overrun}, 32'd0);
    tick();
    ack();
    expect_frame(8'h5A, 1'b0, 1'b0, 8, 0, 1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_fg("after_break");
    ack();

    // Overrun: second frame discarded while the first is held
    expect_frame(8'h11, 1'b0, 1'b0, 8, 0, 1);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    repeat (4) tick();
    @(negedge baud_clk);
    chk("ovr_data_held", {24'd0, Rx_data}, 32'h11);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_fg", {31'd0, Rx_fg}, 32'd1);
    tick();
    ack();
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Short low glitch on the idle line
    Rx_line = 1'b0;
    repeat (OS / 4) tick();
    Rx_line = 1'b1;
    repeat (200) tick();
    @(negedge baud_clk);
    chk("glitch_no_fg", {31'd0, Rx_fg}, 32'd0);
    tick();

    // Reset in the middle of DATA while an unacknowledged frame is held
    expect_frame(8'h77, 1'b0, 1'b0, 8, 0, 1);
    send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_fg("pre_reset");
    tick();
    Rx_line = 1'b0;
    repeat (OS) tick();
    Rx_line = 1'b1;
    repeat (3 * OS) tick();
    rst_n = 1'b0;
    @(negedge baud_clk);
    chk_all_zero("mid_reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    expect_frame(8'hC3, 1'b0, 1'b0, 8, 0, 1);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_fg("post_reset");
    ack();

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inversion on every mid-bit sample is outvoted
    expect_frame(8'h3C, 1'b0, 1'b0, 8, 0, 1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_fg("majority");
    ack();
`endif

    repeat (20) tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
